// File: rtl/elevator_pkg.sv
// elevator_pkg: shared direction/door/motion codes and floor-range helper
// for the elevator control blocks.
package elevator_pkg;

    typedef enum logic [1:0] {
        STOP   = 2'b00,
        DOWN   = 2'b01,
        UP     = 2'b10,
        UPDOWN = 2'b11
    } dir_t;

    localparam logic ON    = 1'b1;
    localparam logic OFF   = 1'b0;
    localparam logic OPEN  = 1'b1;
    localparam logic CLOSE = 1'b0;
    localparam logic MOVE  = 1'b1;
    localparam logic HOLD  = 1'b0;

    function automatic logic floor_valid(input int floor, input int n);
        return floor >= 1 && floor <= n;
    endfunction

endpackage

// File: rtl/request_bank.sv
// request_bank: N-bit request latch vector; a press beats a same-cycle clear,
// and bits outside MASK are held at 0.
module request_bank
    import elevator_pkg::*;
#(
    parameter int             N    = 7,
    parameter logic [N-1:0]   MASK = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] press,
    input  logic [N-1:0] clear,
    output logic [N-1:0] lamp
);

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            lamp <= '0;
        else if (enable)
            lamp <= (press | (lamp & ~clear)) & MASK;

endmodule

// File: rtl/director_sched.sv
// director_sched: N-floor direction scheduler with latched hall/car requests,
// service clearing, idle return-to-home and sticky invalid-floor detection.
module director_sched
    import elevator_pkg::*;
#(
    parameter int N_FLOORS     = 7,
    parameter int FLOOR_W      = 3,
    parameter int HOME_FLOOR   = 1,
    parameter int IDLE_TIMEOUT = 1000,
    parameter int TIMER_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [FLOOR_W-1:0]  currentFloor,
    input  logic                move,
    input  logic                doorState,
    input  logic [N_FLOORS-1:0] hallUpPress,
    input  logic [N_FLOORS-1:0] hallDownPress,
    input  logic [N_FLOORS-1:0] carPress,
    output logic [N_FLOORS-1:0] hallUpLamp,
    output logic [N_FLOORS-1:0] hallDownLamp,
    output logic [N_FLOORS-1:0] carLamp,
    output logic [1:0]          nextDirection,
    output logic                homeActive,
    output logic                floorError
);

    localparam logic [N_FLOORS-1:0] HOME_BIT  = N_FLOORS'(1) << (HOME_FLOOR - 1);
    localparam logic [N_FLOORS-1:0] UP_MASK   = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DOWN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};
    localparam logic [TIMER_W-1:0]  LAST      = TIMER_W'(IDLE_TIMEOUT == 0 ? 0 : IDLE_TIMEOUT - 1);

    dir_t                state, state_nxt;
    int                  cf;
    logic                valid, hold_closed, service, any_above, any_below, idle, lamps_any;
    logic [N_FLOORS-1:0] at_floor, req, up_clr, down_clr;
    logic [TIMER_W-1:0]  idle_cnt;

    assign cf          = int'(currentFloor);
    assign valid       = floor_valid(cf, N_FLOORS);
    assign hold_closed = move == HOLD && doorState == CLOSE;
    assign service     = valid && move == HOLD && doorState == OPEN;
    assign lamps_any   = |(hallUpLamp | hallDownLamp | carLamp);
    // A pending home return behaves like a car call to HOME_FLOOR.
    assign req         = hallUpLamp | hallDownLamp | carLamp | (homeActive ? HOME_BIT : '0);

    always_comb begin
        at_floor  = '0;
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            at_floor[i] = service && cf == i + 1;
            any_above   = any_above | (valid && req[i] && i + 1 > cf);
            any_below   = any_below | (valid && req[i] && i + 1 < cf);
        end
    end

    // Hall calls are only answered by a car heading their way (or idle).
    assign up_clr   = (state == UP   || state == STOP) ? at_floor : '0;
    assign down_clr = (state == DOWN || state == STOP) ? at_floor : '0;

    request_bank #(.N(N_FLOORS), .MASK(UP_MASK)) u_hall_up (
        .clk(clk), .reset(reset), .enable(enable),
        .press(hallUpPress), .clear(up_clr), .lamp(hallUpLamp)
    );

    request_bank #(.N(N_FLOORS), .MASK(DOWN_MASK)) u_hall_down (
        .clk(clk), .reset(reset), .enable(enable),
        .press(hallDownPress), .clear(down_clr), .lamp(hallDownLamp)
    );

    request_bank #(.N(N_FLOORS)) u_car (
        .clk(clk), .reset(reset), .enable(enable),
        .press(carPress), .clear(at_floor), .lamp(carLamp)
    );

    always_comb begin
        state_nxt = state;
        if (!valid)
            state_nxt = STOP;
        else if (hold_closed)
            state_nxt = (state == DOWN && any_below) ? DOWN :
                        any_above ? UP : any_below ? DOWN : STOP;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            state <= STOP;
        else if (enable)
            state <= state_nxt;

    assign nextDirection = state;

    assign idle = IDLE_TIMEOUT != 0 && state == STOP && hold_closed && !lamps_any &&
                  !homeActive && cf != HOME_FLOOR;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            idle_cnt   <= '0;
            homeActive <= 1'b0;
            floorError <= 1'b0;
        end else if (enable) begin
            idle_cnt   <= (idle && idle_cnt != LAST) ? idle_cnt + 1'b1 : '0;
            floorError <= floorError | !valid;
            if (idle && idle_cnt == LAST)
                homeActive <= 1'b1;
            else if (service && cf == HOME_FLOOR)
                homeActive <= 1'b0;
        end

endmodule

// File: tb/tb_director_sched.sv
// tb_director_sched: directed scenarios plus random traffic, checked against a
// floor-by-floor behavioural model of the scheduler.
module tb_director_sched;

    localparam int N    = 7;
    localparam int FW   = 3;
    localparam int HOME = 1;
    localparam int TO   = 8;
    localparam int ST   = 0;
    localparam int DN   = 1;
    localparam int UPC  = 2;

    logic          clk = 1'b0, reset = 1'b0, enable = 1'b0, move = 1'b0, doorState = 1'b0;
    logic [FW-1:0] currentFloor = 3'd2;
    logic [N-1:0]  hallUpPress = '0, hallDownPress = '0, carPress = '0;
    logic [N-1:0]  hallUpLamp, hallDownLamp, carLamp;
    logic [1:0]    nextDirection;
    logic          homeActive, floorError;

    int total = 0, bad = 0;

    bit m_hu[1:N], m_hd[1:N], m_cl[1:N];
    bit m_home, m_ferr;
    int m_dir, m_cnt;

    director_sched #(.N_FLOORS(N), .FLOOR_W(FW), .HOME_FLOOR(HOME), .IDLE_TIMEOUT(TO), .TIMER_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .currentFloor(currentFloor),
        .move(move), .doorState(doorState), .hallUpPress(hallUpPress),
        .hallDownPress(hallDownPress), .carPress(carPress), .hallUpLamp(hallUpLamp),
        .hallDownLamp(hallDownLamp), .carLamp(carLamp), .nextDirection(nextDirection),
        .homeActive(homeActive), .floorError(floorError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int f = 1; f <= N; f++) begin
            m_hu[f] = 0; m_hd[f] = 0; m_cl[f] = 0;
        end
        m_home = 0; m_ferr = 0; m_dir = ST; m_cnt = 0;
    endtask

    // One enabled clock edge worth of scheduler behaviour, from current inputs.
    task automatic model_step();
        bit valid, above, below, busy, idle, r, serve;
        int cf, nd;
        if (!enable) return;
        cf = int'(currentFloor);
        valid = cf >= 1 && cf <= N;
        above = 0; below = 0; busy = 0;
        for (int f = 1; f <= N; f++) begin
            r = m_hu[f] | m_hd[f] | m_cl[f] | (m_home && f == HOME);
            busy |= m_hu[f] | m_hd[f] | m_cl[f];
            if (valid && r && f > cf) above = 1;
            if (valid && r && f < cf) below = 1;
        end
        idle = m_dir == ST && !move && !doorState && !busy && !m_home && cf != HOME;
        if (!valid) nd = ST;
        else if (move || doorState) nd = m_dir;
        else if (m_dir == DN && below) nd = DN;
        else nd = above ? UPC : below ? DN : ST;
        for (int f = 1; f <= N; f++) begin
            serve = valid && !move && doorState && f == cf;
            m_cl[f] = carPress[f-1] | (m_cl[f] & !serve);
            m_hu[f] = (f < N) && (hallUpPress[f-1] | (m_hu[f] & !(serve && m_dir != DN)));
            m_hd[f] = (f > 1) && (hallDownPress[f-1] | (m_hd[f] & !(serve && m_dir != UPC)));
        end
        if (valid && !move && doorState && cf == HOME) m_home = 0;
        if (!idle) m_cnt = 0;
        else if (m_cnt == TO - 1) begin m_home = 1; m_cnt = 0; end
        else m_cnt++;
        if (!valid) m_ferr = 1;
        m_dir = nd;
    endtask

    task automatic check_all();
        logic [N-1:0] hu, hd, cl;
        for (int f = 1; f <= N; f++) begin
            hu[f-1] = m_hu[f]; hd[f-1] = m_hd[f]; cl[f-1] = m_cl[f];
        end
        chk("hallUpLamp", hallUpLamp, hu);
        chk("hallDownLamp", hallDownLamp, hd);
        chk("carLamp", carLamp, cl);
        chk("nextDirection", nextDirection, m_dir);
        chk("homeActive", homeActive, m_home);
        chk("floorError", floorError, m_ferr);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b1;

        // basic up travel and car-call service
        carPress = 7'h10; step();
        chk("basic_lamp", carLamp, 7'h10);
        carPress = '0; step();
        chk("basic_dir_up", nextDirection, 2'b10);
        currentFloor = 3'd5; doorState = 1'b1; step();
        chk("basic_served", carLamp, 7'h00);
        doorState = 1'b0; step();
        chk("basic_stop", nextDirection, 2'b00);

        // idle home return after exactly TO enabled cycles
        for (int i = 1; i <= TO; i++) begin
            step();
            chk("idle_home", homeActive, i == TO);
        end
        step();
        chk("home_dir_down", nextDirection, 2'b01);
        currentFloor = 3'd1; doorState = 1'b1; step();
        chk("home_cleared", homeActive, 1'b0);
        doorState = 1'b0; step();
        chk("home_stop", nextDirection, 2'b00);

        // press part-way through the idle count cancels the home return
        currentFloor = 3'd5;
        for (int i = 0; i < 4; i++) step();
        carPress = 7'h04; step();
        carPress = '0;
        for (int i = 0; i < TO; i++) begin
            step();
            chk("idle_cancel", homeActive, 1'b0);
        end
        currentFloor = 3'd3; doorState = 1'b1; step();
        doorState = 1'b0; step();
        chk("cancel_stop", nextDirection, 2'b00);

        // UP beats DOWN from STOP, then reverse, then stop
        currentFloor = 3'd4; carPress = 7'h22; step();
        carPress = '0; step();
        chk("prio_up", nextDirection, 2'b10);
        currentFloor = 3'd6; doorState = 1'b1; step();
        doorState = 1'b0; step();
        chk("prio_down", nextDirection, 2'b01);
        currentFloor = 3'd2; doorState = 1'b1; step();
        doorState = 1'b0; step();
        chk("prio_stop", nextDirection, 2'b00);

        // hall clear follows travel direction
        currentFloor = 3'd3; carPress = 7'h40; hallUpPress = 7'h04; hallDownPress = 7'h04; step();
        carPress = '0; hallUpPress = '0; hallDownPress = '0; step();
        chk("hall_dir_up", nextDirection, 2'b10);
        doorState = 1'b1; step();
        chk("hall_up_clr", hallUpLamp, 7'h00);
        chk("hall_down_keep", hallDownLamp, 7'h04);

        // tied-off hall buttons
        hallUpPress = 7'h40; hallDownPress = 7'h01; step();
        hallUpPress = '0; hallDownPress = '0;
        chk("tie_up_top", hallUpLamp[6], 1'b0);
        chk("tie_down_bottom", hallDownLamp[0], 1'b0);

        // invalid floor forces STOP and sets the sticky error
        doorState = 1'b0; currentFloor = 3'd0; step();
        chk("inv_stop", nextDirection, 2'b00);
        chk("inv_err", floorError, 1'b1);
        currentFloor = 3'd3; step();
        chk("inv_sticky", floorError, 1'b1);

        // disabled: presses ignored
        enable = 1'b0; carPress = '1; hallUpPress = '1; step();
        chk("en_hold_car", carLamp, 7'h40);
        enable = 1'b1; carPress = '0; hallUpPress = '0;

        // asynchronous reset mid-move with lamps set
        move = 1'b1;
        model_step();
        @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        #1;
        chk("rst_car", carLamp, 7'h00);
        chk("rst_dir", nextDirection, 2'b00);
        check_all();
        @(negedge clk);
        reset = 1'b1;
        move = 1'b0;

        // random traffic
        for (int c = 0; c < 600; c++) begin
            enable        = $urandom_range(0, 9) != 0;
            move          = $urandom_range(0, 3) == 0;
            doorState     = $urandom_range(0, 2) == 0;
            currentFloor  = $urandom_range(0, 39) == 0 ? 3'd0 : FW'($urandom_range(1, N));
            carPress      = $urandom_range(0, 5) == 0 ? N'($urandom) : '0;
            hallUpPress   = $urandom_range(0, 7) == 0 ? N'($urandom) : '0;
            hallDownPress = $urandom_range(0, 7) == 0 ? N'($urandom) : '0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/director_sched.md
Name: director_sched

Overview:
- Parametrised successor to the two-way car direction controller.
- Generalised to N_FLOORS floors, with latched hall and car requests and per-floor lamp outputs.
- Adds service-clearing of requests on arrival, idle return-to-home with a timeout, and invalid-floor detection.
- Sits between the button/door logic and the motor sequencer, and drives the 2-bit nextDirection code consumed by the sequencer.

Parameters:
- N_FLOORS, 7: number of floors, numbered 1..N_FLOORS (min 2).
- FLOOR_W, 3: width of the floor index; must satisfy 2**FLOOR_W > N_FLOORS.
- HOME_FLOOR, 1: floor the car returns to when idle.
- IDLE_TIMEOUT, 1000: enabled idle cycles before a home return; 0 disables the feature.
- TIMER_W, 16: idle counter width; IDLE_TIMEOUT must fit in it.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  clock enable; when low, all state holds and presses are ignored
- currentFloor  in  FLOOR_W  floor the car is at (1-based)
- move  in  1  1=MOVE, 0=HOLD
- doorState  in  1  1=OPEN, 0=CLOSE
- hallUpPress  in  N_FLOORS  bit f-1 = up button at floor f
- hallDownPress  in  N_FLOORS  bit f-1 = down button at floor f
- carPress  in  N_FLOORS  bit f-1 = in-car button for floor f
- hallUpLamp  out  N_FLOORS  latched up requests
- hallDownLamp  out  N_FLOORS  latched down requests
- carLamp  out  N_FLOORS  latched car requests
- nextDirection  out  2  STOP=00, UP=10, DOWN=01; 11 is never driven
- homeActive  out  1  idle home-return request pending
- floorError  out  1  sticky flag: invalid currentFloor seen

Behaviour:
- Reset (reset=0, asynchronous):
  - all lamps 0, nextDirection=STOP, homeActive=0, floorError=0, idle counter=0.
  - Reset mid-travel discards all requests.
- All updates happen on posedge clk, and only when enable=1 and reset=1.
- Request latches:
  - A press bit high sets its lamp; lamp visible one cycle later.
  - hallUpPress at floor N_FLOORS and hallDownPress at floor 1 are ignored; those lamps are tied to 0.
- Service clear: applies when move=HOLD, doorState=OPEN and currentFloor=f is valid.
  - carLamp[f] clears.
  - hallUpLamp[f] clears if nextDirection is UP or STOP.
  - hallDownLamp[f] clears if nextDirection is DOWN or STOP.
  - homeActive clears if f=HOME_FLOOR.
- Press and clear of the same bit in the same cycle: the press wins and the lamp stays 1.
- anyAbove / anyBelow:
  - Computed from the registered lamps plus homeActive, treated as a car request at HOME_FLOOR.
  - anyAbove = any request at a floor > currentFloor; anyBelow = any request at a floor < currentFloor.
  - Consequence: a press at cycle t first affects nextDirection at t+2.
- Direction FSM: the state is nextDirection. It is evaluated only when move=HOLD and doorState=CLOSE; otherwise it holds.
  - STOP: anyAbove -> UP; else anyBelow -> DOWN; else stay STOP. If both are set, UP wins.
  - UP: anyAbove -> stay UP; else anyBelow -> DOWN; else STOP.
  - DOWN: anyBelow -> stay DOWN; else anyAbove -> UP; else STOP.
- Idle timer:
  - Counts up when all of the following hold: nextDirection=STOP, move=HOLD, doorState=CLOSE, no lamps set, homeActive=0, currentFloor!=HOME_FLOOR, IDLE_TIMEOUT!=0.
  - Clears to 0 whenever any of those conditions fails.
  - When the count reaches IDLE_TIMEOUT-1 and the conditions still hold: homeActive=1 on the next edge and the counter clears.
  - The counter never wraps.
- Invalid floor (currentFloor=0 or >N_FLOORS):
  - anyAbove=anyBelow=0, no service clear, nextDirection forced to STOP, floorError set.
  - floorError clears only on reset.

Decomposition:
- Shared package elevator_pkg holds:
  - direction codes STOP/UP/DOWN/UPDOWN
  - ON/OFF, OPEN/CLOSE, MOVE/HOLD
  - a function floor_valid(floor, n).
- One sub-module, request_bank: an N-bit set/clear latch vector with the press-wins rule, instantiated three times (hall up, hall down, car).
- The direction FSM, the above/below reduction loops and the idle timer live in director_sched.

Test Plan:
- Reset: assert reset=0 mid-move with lamps set -> all lamps 0, nextDirection=00, homeActive=0 immediately, before the clock edge.
- Basic up: currentFloor=2, door closed, HOLD, pulse carPress[4] (floor 5) at cycle t -> carLamp=0x10 at t+1, nextDirection=10 at t+2. Then floor 5, door OPEN -> carLamp=0 next edge.
- Direction priority: at floor 4, STOP, press car floors 2 and 6 in the same cycle -> UP. After floor 6 is served and the door closes -> DOWN, then STOP after floor 2 is served.
- Hall clear rule: at floor 3 with nextDirection=UP, hallUpLamp[2] and hallDownLamp[2] set, door OPEN -> only hallUpLamp[2] clears; hallDownLamp[2] remains 1.
- Idle home: IDLE_TIMEOUT=8, floor 5, idle -> homeActive=1 after exactly 8 enabled cycles, nextDirection=01 next eligible edge. Arrival at floor 1 with door OPEN -> homeActive=0. A press at cycle 5 of the count -> counter clears and homeActive is never set.
- Invalid floor and enable: currentFloor=0 while UP -> nextDirection=00, floorError=1, sticky after the floor becomes valid. With enable=0, presses produce no lamp change.
